// File: rtl/branch_unit_if.sv
`default_nettype none
// branch_unit_if : decoder/flag/PC-side bundle of the branch resolver.
// Rev 1.0 - initial release.
interface branch_unit_if #(
    parameter int BITS = 16
);
    logic            br_valid;
    logic            br_ready;
    logic [3:0]      br_cond;
    logic [BITS-1:0] br_target;
    logic [BITS-1:0] br_pc;
    logic            br_link;
    logic            C;
    logic            Z;
    logic            S;
    logic            flags_pending;
    logic            pc_load;
    logic [BITS-1:0] pc_out;
    logic            flush;
    logic            br_done;
    logic            br_taken;
    logic            lr_we;
    logic [BITS-1:0] lr_out;

    modport master (
        output br_valid, br_cond, br_target, br_pc, br_link,
        output C, Z, S, flags_pending,
        input  br_ready, pc_load, pc_out, flush, br_done, br_taken, lr_we, lr_out
    );

    modport slave (
        input  br_valid, br_cond, br_target, br_pc, br_link,
        input  C, Z, S, flags_pending,
        output br_ready, pc_load, pc_out, flush, br_done, br_taken, lr_we, lr_out
    );
endinterface
`default_nettype wire

// File: rtl/branch_unit.sv
`default_nettype none
// branch_unit : resolves C/Z/S conditional branches, drives PC load and a timed flush.
// Rev 1.0 - link-register write built only when BRANCH_LINK_EN is defined.
module branch_unit #(
    parameter int BITS         = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  wire logic      CLK,
    input  wire logic      RSTb,
    branch_unit_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVAL  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Counter holds the remaining flush cycles after the current one.
    localparam logic [3:0] c_flush_init = 4'(FLUSH_CYCLES - 1);

    state_t          state_q, state_d;
    logic [3:0]      cond_q, cond_d;
    logic [BITS-1:0] target_q, target_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [BITS-1:0] pc_out_q, pc_out_d;
    logic            pc_load_q, pc_load_d;
    logic            flush_q, flush_d;
    logic            done_q, done_d;
    logic            taken_q, taken_d;
    logic            w_cond_true;

    always_comb begin
        w_cond_true = 1'b0;
        case (cond_q)
            4'd0:    w_cond_true = 1'b1;
            4'd1:    w_cond_true = bus.Z;
            4'd2:    w_cond_true = !bus.Z;
            4'd3:    w_cond_true = bus.S;
            4'd4:    w_cond_true = !bus.S;
            4'd5:    w_cond_true = bus.C;
            4'd6:    w_cond_true = !bus.C;
            4'd7:    w_cond_true = bus.C | bus.Z;
            4'd8:    w_cond_true = !bus.C & !bus.Z;
            4'd9:    w_cond_true = bus.S | bus.Z;
            4'd10:   w_cond_true = !bus.S & !bus.Z;
            default: w_cond_true = 1'b0;
        endcase
    end

`ifdef BRANCH_LINK_EN
    localparam logic [BITS-1:0] c_one = {{(BITS-1){1'b0}}, 1'b1};

    logic            link_q, link_d;
    logic [BITS-1:0] brpc_q, brpc_d;
    logic            lr_we_q, lr_we_d;
    logic [BITS-1:0] lr_out_q, lr_out_d;
`else
    logic w_unused_link;
    assign w_unused_link = ^{bus.br_link, bus.br_pc};
`endif

    always_comb begin
        state_d   = state_q;
        cond_d    = cond_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        pc_out_d  = pc_out_q;
        flush_d   = flush_q;
        pc_load_d = 1'b0;
        done_d    = 1'b0;
        taken_d   = 1'b0;
`ifdef BRANCH_LINK_EN
        link_d    = link_q;
        brpc_d    = brpc_q;
        lr_we_d   = 1'b0;
        lr_out_d  = lr_out_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.br_valid) begin
                    cond_d   = bus.br_cond;
                    target_d = bus.br_target;
`ifdef BRANCH_LINK_EN
                    link_d   = bus.br_link;
                    brpc_d   = bus.br_pc;
`endif
                    state_d  = S_EVAL;
                end
            end
            S_EVAL: begin
                // An ALU op in flight will rewrite the flags; wait until they settle.
                if (!bus.flags_pending) begin
                    done_d = 1'b1;
                    if (w_cond_true) begin
                        taken_d   = 1'b1;
                        pc_load_d = 1'b1;
                        pc_out_d  = target_q;
                        flush_d   = 1'b1;
                        cnt_d     = c_flush_init;
                        state_d   = S_FLUSH;
`ifdef BRANCH_LINK_EN
                        if (link_q) begin
                            lr_we_d  = 1'b1;
                            lr_out_d = brpc_q + c_one;
                        end
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    flush_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q   <= S_IDLE;
            cond_q    <= 4'd0;
            target_q  <= '0;
            cnt_q     <= 4'd0;
            pc_out_q  <= '0;
            pc_load_q <= 1'b0;
            flush_q   <= 1'b0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cond_q    <= cond_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            pc_out_q  <= pc_out_d;
            pc_load_q <= pc_load_d;
            flush_q   <= flush_d;
            done_q    <= done_d;
            taken_q   <= taken_d;
        end
    end

`ifdef BRANCH_LINK_EN
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            link_q   <= 1'b0;
            brpc_q   <= '0;
            lr_we_q  <= 1'b0;
            lr_out_q <= '0;
        end else begin
            link_q   <= link_d;
            brpc_q   <= brpc_d;
            lr_we_q  <= lr_we_d;
            lr_out_q <= lr_out_d;
        end
    end

    assign bus.lr_we  = lr_we_q;
    assign bus.lr_out = lr_out_q;
`else
    assign bus.lr_we  = 1'b0;
    assign bus.lr_out = '0;
`endif

    assign bus.br_ready = (state_q == S_IDLE);
    assign bus.pc_load  = pc_load_q;
    assign bus.pc_out   = pc_out_q;
    assign bus.flush    = flush_q;
    assign bus.br_done  = done_q;
    assign bus.br_taken = taken_q;
endmodule
`default_nettype wire
